menu_write_arbiter: RTL and testbench
=====================================

// Module: menu_write_arbiter
// PURPOSE
//  Shares the menu text-buffer write port (10-bit addr, 8-bit char) between NUM_REQ writers:
//  config-menu updater, processor status line, audio readout and debug overlay.
//  Round-robin arbitration with burst locking, so multi-char fields (e.g. 12-char game name)
//  land without interleaving. Sits between the writers and the text-buffer BRAM port A.
// PARAMETERS
//  NUM_REQ    4    number of requesters (>=2)
//  ADDR_W     10   text-buffer address width
//  DATA_W     8    character code width
//  MAX_BURST  16   max beats one grant may hold before forced release
// PORTS
//  clk_in           in   1                 system clock; single clock domain
//  rst_n_in         in   1                 synchronous reset, active-low
//  req_valid_in     in   NUM_REQ           per-requester beat valid
//  req_last_in      in   NUM_REQ           beat is final of burst (single beat: last=1)
//  req_addr_in      in   NUM_REQ*ADDR_W    packed, requester i at [i*ADDR_W +: ADDR_W]
//  req_data_in      in   NUM_REQ*DATA_W    packed, requester i at [i*DATA_W +: DATA_W]
//  req_ready_out    out  NUM_REQ           beat of requester i accepted when valid&ready
//  write_valid_out  out  1                 text-buffer write strobe (registered)
//  write_addr_out   out  ADDR_W            text-buffer write address (registered)
//  write_data_out   out  DATA_W            text-buffer write data (registered)
//  grant_out        out  NUM_REQ           one-hot current owner; 0 when unlocked
//  busy_out         out  1                 1 while in LOCKED
// BEHAVIOUR
//  - Reset (rst_n_in=0 at posedge): state=IDLE, write_valid_out=0, write_addr_out=0,
//    write_data_out=0, grant_out=0, beat count=0, rr pointer=NUM_REQ-1 (req 0 highest first).
//    Reset mid-burst abandons the burst; no write issued the following cycle.
//  - req_ready_out combinational from state + req_valid_in; at most one bit set per cycle.
//  - IDLE: winner = first valid requester scanning ptr+1, ptr+2 .. ptr (mod NUM_REQ);
//    ready to winner only. None valid -> no ready, write_valid_out<=0.
//    Accepted beat with last=1 -> stay IDLE, ptr<=winner. last=0 -> LOCKED, owner<=winner,
//    grant_out<=onehot(winner), count<=1.
//  - LOCKED: ready only to owner (asserted whenever owner valid); others stall.
//    Owner valid=0 -> bubble: write_valid_out<=0, lock held, count unchanged.
//    Accepted beat: count++; if last=1 or count+1==MAX_BURST -> IDLE, ptr<=owner,
//    grant_out<=0; else stay.
//  - Latency: accepted beat appears on write_* exactly 1 cycle after acceptance;
//    write_valid_out=1 only in cycles following an accepted beat. Throughput 1 beat/cycle,
//    including back-to-back single beats from different requesters (no dead cycle on switch).
//  - Forced release at MAX_BURST: requester's later beats re-arbitrate as a new burst;
//    no error flag.
//  - Address/data passed through unmodified; no range check (buffer ignores addr >= depth).
//  - Valid/addr/data/last of a non-ready requester must hold stable until accepted
//    (requester obligation; bench asserts it).
//  - Count width $clog2(MAX_BURST+1); ptr width $clog2(NUM_REQ).
// STRUCTURE
//  - menu_pkg: TEXT_ADDR_W=10, TEXT_DATA_W=8, arb_state_t enum {ARB_IDLE, ARB_LOCKED},
//    requester index constants (REQ_CONFIG=0, REQ_CPU=1, REQ_AUDIO=2, REQ_DEBUG=3).
//  - Sub-module rr_pick #(N): combinational round-robin picker
//    (req vector, ptr) -> one-hot grant + index + any; reusable elsewhere.
//  - FSM, counter and output registers in one always_ff; ready/mux in always_comb.
// TESTING
//  1. Reset: hold rst_n_in=0 3 cycles with all req_valid=1 -> write_valid_out=0,
//     grant_out=0, ready=0.
//  2. Round-robin: all 4 single beats (last=1) held valid, addr=i*100
//     -> writes addr 0,100,200,300,0.. one per cycle, no gaps.
//  3. Burst lock: req1 12 beats addr 128..139 last on 12th, req2 valid throughout
//     -> 12 consecutive req1 writes, then req2; req2 ready=0 during the burst.
//  4. Bubble: req0 burst, valid dropped 2 cycles mid-burst -> 2 write_valid=0 cycles,
//     grant_out stays 4'b0001, req3 not served.
//  5. MAX_BURST: req3 20 beats never last -> 16 writes, release, other pending
//     requester served, then req3 resumes.
//  6. Reset mid-burst at beat 5 -> next cycle write_valid_out=0; after release
//     req0 wins first.

Source files
------------

// File: rtl/menu_write_arbiter_pkg.sv
// Shared constants and types for the menu text-buffer write path.
// Writer indices match the port order used by every menu-buffer client.
package menu_pkg;

  localparam int TEXT_ADDR_W = 10;
  localparam int TEXT_DATA_W = 8;
  localparam int NUM_WRITERS = 4;

  localparam int REQ_CONFIG = 0;
  localparam int REQ_CPU    = 1;
  localparam int REQ_AUDIO  = 2;
  localparam int REQ_DEBUG  = 3;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Width of a counter that must hold the value max_val.
  function automatic int count_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/menu_write_arbiter_if.sv
// Packed multi-writer beat bus feeding the text-buffer write arbiter.
// Writer i occupies bit i of the vectors and slice i of the packed addr/data fields.
interface menu_write_arbiter_if import menu_pkg::*; #(
  parameter int NUM_REQ = NUM_WRITERS,
  parameter int ADDR_W  = TEXT_ADDR_W,
  parameter int DATA_W  = TEXT_DATA_W
) ();

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  modport master (
    output req_valid,
    output req_last,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_last,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/menu_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping, ptr itself last.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant_onehot,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_any
);

  // Scan from the farthest candidate to the nearest so the nearest hit overwrites.
  always_comb begin
    int cand_s;
    cand_s       = 0;
    grant_onehot = {N{1'b0}};
    grant_idx    = {PTR_W{1'b0}};
    grant_any    = 1'b0;
    for (int k = N; k >= 1; k--) begin
      cand_s = (int'(ptr) + k) % N;
      if (req[cand_s]) begin
        grant_onehot         = {N{1'b0}};
        grant_onehot[cand_s] = 1'b1;
        grant_idx            = PTR_W'(cand_s);
        grant_any            = 1'b1;
      end else begin
        grant_any = grant_any;
      end
    end
  end

endmodule

// File: rtl/menu_write_arbiter.sv
// Round-robin arbiter with burst locking in front of the menu text-buffer write port.
// Multi-beat fields hold the port until their last beat or MAX_BURST beats, whichever is first.
module menu_write_arbiter import menu_pkg::*; #(
  parameter int NUM_REQ   = NUM_WRITERS,
  parameter int ADDR_W    = TEXT_ADDR_W,
  parameter int DATA_W    = TEXT_DATA_W,
  parameter int MAX_BURST = 16
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  menu_write_arbiter_if.slave req_bus,
  output logic                write_valid_out,
  output logic [ADDR_W-1:0]   write_addr_out,
  output logic [DATA_W-1:0]   write_data_out,
  output logic [NUM_REQ-1:0]  grant_out,
  output logic                busy_out
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = count_width(MAX_BURST);
  localparam logic [PTR_W-1:0] PTR_RESET = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  arb_state_t           state_r;
  arb_state_t           state_next_s;
  logic [PTR_W-1:0]     ptr_r;
  logic [PTR_W-1:0]     ptr_next_s;
  logic [PTR_W-1:0]     owner_r;
  logic [PTR_W-1:0]     owner_next_s;
  logic [CNT_W-1:0]     count_r;
  logic [CNT_W-1:0]     count_next_s;
  logic [NUM_REQ-1:0]   grant_next_s;

  logic [NUM_REQ-1:0]   pick_onehot_s;
  logic [PTR_W-1:0]     pick_idx_s;
  logic                 pick_any_s;

  logic [NUM_REQ-1:0]   ready_s;
  logic [PTR_W-1:0]     sel_idx_s;
  logic                 accept_s;
  logic                 sel_last_s;
  logic [ADDR_W-1:0]    sel_addr_s;
  logic [DATA_W-1:0]    sel_data_s;

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req          (req_bus.req_valid),
    .ptr          (ptr_r),
    .grant_onehot (pick_onehot_s),
    .grant_idx    (pick_idx_s),
    .grant_any    (pick_any_s)
  );

  // Ready is held off during reset so no beat is consumed while the arbiter is cleared.
  always_comb begin
    ready_s   = {NUM_REQ{1'b0}};
    sel_idx_s = owner_r;
    if (!rst_n_in) begin
      ready_s = {NUM_REQ{1'b0}};
    end else begin
      case (state_r)
        ARB_IDLE: begin
          sel_idx_s = pick_idx_s;
          ready_s   = pick_any_s ? pick_onehot_s : {NUM_REQ{1'b0}};
        end
        ARB_LOCKED: begin
          sel_idx_s        = owner_r;
          ready_s[owner_r] = req_bus.req_valid[owner_r];
        end
        default: begin
          ready_s = {NUM_REQ{1'b0}};
        end
      endcase
    end
  end

  // Beat mux from the selected writer.
  always_comb begin
    accept_s   = |ready_s;
    sel_last_s = req_bus.req_last[sel_idx_s];
    sel_addr_s = req_bus.req_addr[int'(sel_idx_s) * ADDR_W +: ADDR_W];
    sel_data_s = req_bus.req_data[int'(sel_idx_s) * DATA_W +: DATA_W];
  end

  assign req_bus.req_ready = ready_s;

  // Next-state, owner, pointer and beat-count decisions.
  always_comb begin
    state_next_s = state_r;
    ptr_next_s   = ptr_r;
    owner_next_s = owner_r;
    count_next_s = count_r;
    grant_next_s = grant_out;
    case (state_r)
      ARB_IDLE: begin
        if (accept_s && (sel_last_s || (CNT_ONE == CNT_LIMIT))) begin
          ptr_next_s = sel_idx_s;
        end else if (accept_s) begin
          state_next_s = ARB_LOCKED;
          owner_next_s = sel_idx_s;
          grant_next_s = ready_s;
          count_next_s = CNT_ONE;
        end else begin
          state_next_s = ARB_IDLE;
        end
      end
      ARB_LOCKED: begin
        if (accept_s && (sel_last_s || ((count_r + CNT_ONE) == CNT_LIMIT))) begin
          state_next_s = ARB_IDLE;
          ptr_next_s   = owner_r;
          grant_next_s = {NUM_REQ{1'b0}};
          count_next_s = {CNT_W{1'b0}};
        end else if (accept_s) begin
          count_next_s = count_r + CNT_ONE;
        end else begin
          state_next_s = ARB_LOCKED;
        end
      end
      default: begin
        state_next_s = ARB_IDLE;
        grant_next_s = {NUM_REQ{1'b0}};
        count_next_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter and registered write port.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_r         <= ARB_IDLE;
      ptr_r           <= PTR_RESET;
      owner_r         <= {PTR_W{1'b0}};
      count_r         <= {CNT_W{1'b0}};
      grant_out       <= {NUM_REQ{1'b0}};
      write_valid_out <= 1'b0;
      write_addr_out  <= {ADDR_W{1'b0}};
      write_data_out  <= {DATA_W{1'b0}};
    end else begin
      state_r         <= state_next_s;
      ptr_r           <= ptr_next_s;
      owner_r         <= owner_next_s;
      count_r         <= count_next_s;
      grant_out       <= grant_next_s;
      write_valid_out <= accept_s;
      if (accept_s) begin
        write_addr_out <= sel_addr_s;
        write_data_out <= sel_data_s;
      end else begin
        write_addr_out <= write_addr_out;
        write_data_out <= write_data_out;
      end
    end
  end

  assign busy_out = (state_r == ARB_LOCKED);

endmodule

// File: tb/tb_menu_write_arbiter.sv
// Scenario bench for menu_write_arbiter: per-writer beat queues drive the bus,
// an expected-write queue is filled up front and drained as writes appear.
module tb_menu_write_arbiter;
  import menu_pkg::*;

  localparam int NR = 4;

  logic       clk_in;
  logic       rst_n_in;
  logic       write_valid_out;
  logic [9:0] write_addr_out;
  logic [7:0] write_data_out;
  logic [3:0] grant_out;
  logic       busy_out;

  menu_write_arbiter_if #(.NUM_REQ(NR), .ADDR_W(10), .DATA_W(8)) bus ();

  menu_write_arbiter #(
    .NUM_REQ   (NR),
    .ADDR_W    (10),
    .DATA_W    (8),
    .MAX_BURST (16)
  ) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .req_bus         (bus),
    .write_valid_out (write_valid_out),
    .write_addr_out  (write_addr_out),
    .write_data_out  (write_data_out),
    .grant_out       (grant_out),
    .busy_out        (busy_out)
  );

  always #5 clk_in = ~clk_in;

  // Writers must hold a stalled beat unchanged until it is taken.
  for (genvar g = 0; g < NR; g++) begin : g_hold
    assert property (@(posedge clk_in) disable iff (!rst_n_in)
      (bus.req_valid[g] && !bus.req_ready[g]) |=>
        (bus.req_valid[g] && $stable(bus.req_last[g]) &&
         $stable(bus.req_addr[g*10 +: 10]) && $stable(bus.req_data[g*8 +: 8])));
  end

  typedef struct {
    bit         idle;
    logic       last;
    logic [9:0] addr;
    logic [7:0] data;
  } beat_t;

  typedef struct {
    bit         ok;
    logic [9:0] addr;
    logic [7:0] data;
  } exp_t;

  beat_t bq [NR][$];
  exp_t  exp_q [$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] rdy_s;
  logic [3:0] acc_s;
  logic       wv_s;
  logic [9:0] wa_s;
  logic [7:0] wd_s;
  logic [3:0] gr_s;
  logic       busy_s;
  exp_t       ex;

  task automatic push_beat(input int r, input bit last, input int addr, input int data);
    beat_t b;
    b.idle = 1'b0; b.last = last; b.addr = 10'(addr); b.data = 8'(data);
    bq[r].push_back(b);
  endtask

  task automatic push_idle(input int r);
    beat_t b;
    b.idle = 1'b1; b.last = 1'b0; b.addr = 10'd0; b.data = 8'd0;
    bq[r].push_back(b);
  endtask

  task automatic expect_write(input int addr, input int data);
    exp_t e;
    e.ok = 1'b1; e.addr = 10'(addr); e.data = 8'(data);
    exp_q.push_back(e);
  endtask

  function automatic exp_t next_exp();
    exp_t e;
    e.ok = 1'b0; e.addr = 10'd0; e.data = 8'd0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    return e;
  endfunction

  // Present each writer's queue head; an idle entry costs one cycle of valid=0.
  task automatic present();
    for (int i = 0; i < NR; i++) begin
      if (bq[i].size() == 0) begin
        bus.req_valid[i] = 1'b0;
      end else if (bq[i][0].idle) begin
        bus.req_valid[i] = 1'b0;
        void'(bq[i].pop_front());
      end else begin
        bus.req_valid[i]        = 1'b1;
        bus.req_last[i]         = bq[i][0].last;
        bus.req_addr[i*10 +: 10] = bq[i][0].addr;
        bus.req_data[i*8 +: 8]   = bq[i][0].data;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
    rdy_s = bus.req_ready;
    acc_s = bus.req_valid & bus.req_ready;
    @(posedge clk_in);
    #1;
    wv_s = write_valid_out; wa_s = write_addr_out; wd_s = write_data_out;
    gr_s = grant_out; busy_s = busy_out;
    for (int i = 0; i < NR; i++) begin
      if (acc_s[i] && bq[i].size() > 0) void'(bq[i].pop_front());
    end
    present();
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b1111;
    bus.req_addr  = {10'd300, 10'd200, 10'd100, 10'd0};
    bus.req_data  = 32'h33221100;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_in); rdy_s = bus.req_ready;
      @(posedge clk_in); #1;
      n_cmp++;
      if (write_valid_out !== 1'b0 || grant_out !== 4'b0000 || rdy_s !== 4'b0000 || busy_out !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_hold c=%0d: wv=%b grant=%b ready=%b busy=%b, required 0/0000/0000/0",
                 c, write_valid_out, grant_out, rdy_s, busy_out);
      end
    end
    n_cmp++;
    if (write_addr_out !== 10'd0 || write_data_out !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_regs: addr=%0d data=%0h, required 0/0", write_addr_out, write_data_out);
    end
    rst_n_in = 1'b1;
    present();
    tick();
    n_cmp++;
    if (wv_s !== 1'b0) begin
      n_bad++; $display("FAIL reset_idle: wv=%b, required 0", wv_s);
    end
  endtask

  task automatic test_round_robin();
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < NR; i++) begin
        push_beat(i, 1'b1, i * 100, i * 16 + n);
        expect_write(i * 100, i * 16 + n);
      end
    end
    present();
    for (int t = 1; t <= 12; t++) begin
      tick();
      n_cmp++;
      if (wv_s !== 1'b1) begin
        n_bad++; $display("FAIL rr_gap t=%0d: wv=%b, required 1", t, wv_s);
      end else begin
        ex = next_exp(); n_cmp++;
        if (!ex.ok || wa_s !== ex.addr || wd_s !== ex.data) begin
          n_bad++;
          $display("FAIL rr_write t=%0d: addr %0d data %0h, required addr %0d data %0h", t, wa_s, wd_s, ex.addr, ex.data);
        end
      end
    end
    tick();
    n_cmp++;
    if (wv_s !== 1'b0 || exp_q.size() != 0) begin
      n_bad++; $display("FAIL rr_drain: wv=%b pending=%0d, required 0/0", wv_s, exp_q.size());
    end
  endtask

  task automatic test_burst_lock();
    for (int k = 0; k < 12; k++) begin
      push_beat(REQ_CPU, k == 11, 128 + k, 8'h40 + k);
      expect_write(128 + k, 8'h40 + k);
    end
    for (int n = 0; n < 2; n++) begin
      push_beat(REQ_AUDIO, 1'b1, 500 + n, 8'h60 + n);
      expect_write(500 + n, 8'h60 + n);
    end
    present();
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (t <= 12) begin
        n_cmp++;
        if (rdy_s[REQ_AUDIO] !== 1'b0 || gr_s !== ((t < 12) ? 4'b0010 : 4'b0000)) begin
          n_bad++;
          $display("FAIL burst_lock t=%0d: ready2=%b grant=%b, required 0/%b", t, rdy_s[REQ_AUDIO], gr_s,
                   (t < 12) ? 4'b0010 : 4'b0000);
        end
      end
      n_cmp++;
      if (wv_s !== 1'b1) begin
        n_bad++; $display("FAIL burst_gap t=%0d: wv=%b, required 1", t, wv_s);
      end else begin
        ex = next_exp(); n_cmp++;
        if (!ex.ok || wa_s !== ex.addr || wd_s !== ex.data) begin
          n_bad++;
          $display("FAIL burst_write t=%0d: addr %0d data %0h, required addr %0d data %0h", t, wa_s, wd_s, ex.addr, ex.data);
        end
      end
    end
    tick();
    n_cmp++;
    if (wv_s !== 1'b0 || exp_q.size() != 0) begin
      n_bad++; $display("FAIL burst_drain: wv=%b pending=%0d, required 0/0", wv_s, exp_q.size());
    end
  endtask

  task automatic test_bubble();
    int wv_pat [9] = '{1, 1, 1, 0, 0, 1, 1, 1, 1};
    for (int k = 0; k < 6; k++) begin
      if (k == 3) begin push_idle(REQ_CONFIG); push_idle(REQ_CONFIG); end
      push_beat(REQ_CONFIG, k == 5, 600 + k, 8'h70 + k);
      expect_write(600 + k, 8'h70 + k);
    end
    push_idle(REQ_DEBUG);
    push_beat(REQ_DEBUG, 1'b1, 650, 8'h7F);
    expect_write(650, 8'h7F);
    present();
    for (int t = 1; t <= 9; t++) begin
      tick();
      n_cmp++;
      if (wv_s !== 1'(wv_pat[t-1])) begin
        n_bad++; $display("FAIL bubble_wv t=%0d: wv=%b, required %0d", t, wv_s, wv_pat[t-1]);
      end
      if (t <= 8) begin
        n_cmp++;
        if (rdy_s[REQ_DEBUG] !== 1'b0 || gr_s !== ((t < 8) ? 4'b0001 : 4'b0000)) begin
          n_bad++;
          $display("FAIL bubble_lock t=%0d: ready3=%b grant=%b, required 0/%b", t, rdy_s[REQ_DEBUG], gr_s,
                   (t < 8) ? 4'b0001 : 4'b0000);
        end
      end
      if (wv_s === 1'b1) begin
        ex = next_exp(); n_cmp++;
        if (!ex.ok || wa_s !== ex.addr || wd_s !== ex.data) begin
          n_bad++;
          $display("FAIL bubble_write t=%0d: addr %0d data %0h, required addr %0d data %0h", t, wa_s, wd_s, ex.addr, ex.data);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL bubble_drain: pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_max_burst();
    for (int k = 0; k < 20; k++) push_beat(REQ_DEBUG, 1'b0, 700 + k, 8'h80 + k);
    push_idle(REQ_CPU);
    push_beat(REQ_CPU, 1'b1, 750, 8'hC0);
    for (int k = 0; k < 16; k++) expect_write(700 + k, 8'h80 + k);
    expect_write(750, 8'hC0);
    for (int k = 16; k < 20; k++) expect_write(700 + k, 8'h80 + k);
    present();
    for (int t = 1; t <= 21; t++) begin
      tick();
      if (t == 15 || t == 16) begin
        n_cmp++;
        if (gr_s !== ((t == 15) ? 4'b1000 : 4'b0000)) begin
          n_bad++; $display("FAIL maxb_release t=%0d: grant=%b", t, gr_s);
        end
      end
      if (t >= 2 && t <= 16) begin
        n_cmp++;
        if (rdy_s[REQ_CPU] !== 1'b0) begin
          n_bad++; $display("FAIL maxb_stall t=%0d: ready1=%b, required 0", t, rdy_s[REQ_CPU]);
        end
      end
      n_cmp++;
      if (wv_s !== 1'b1) begin
        n_bad++; $display("FAIL maxb_gap t=%0d: wv=%b, required 1", t, wv_s);
      end else begin
        ex = next_exp(); n_cmp++;
        if (!ex.ok || wa_s !== ex.addr || wd_s !== ex.data) begin
          n_bad++;
          $display("FAIL maxb_write t=%0d: addr %0d data %0h, required addr %0d data %0h", t, wa_s, wd_s, ex.addr, ex.data);
        end
      end
    end
    tick();
    n_cmp++;
    if (wv_s !== 1'b0 || gr_s !== 4'b1000 || busy_s !== 1'b1 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL maxb_relock: wv=%b grant=%b busy=%b pending=%0d, required 0/1000/1/0", wv_s, gr_s, busy_s, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    rst_n_in = 1'b0;
    for (int i = 0; i < NR; i++) bq[i].delete();
    present();
    tick();
    rst_n_in = 1'b1;
    for (int k = 0; k < 8; k++) push_beat(REQ_AUDIO, k == 7, 800 + k, 8'hA0 + k);
    for (int k = 0; k < 3; k++) push_idle(REQ_CONFIG);
    push_beat(REQ_CONFIG, 1'b1, 900, 8'hEE);
    for (int k = 0; k < 4; k++) expect_write(800 + k, 8'hA0 + k);
    present();
    for (int t = 1; t <= 10; t++) begin
      if (t == 5) rst_n_in = 1'b0;
      if (t == 6) begin
        rst_n_in = 1'b1;
        expect_write(900, 8'hEE);
        for (int k = 4; k < 8; k++) expect_write(800 + k, 8'hA0 + k);
      end
      tick();
      if (t == 5) begin
        n_cmp++;
        if (wv_s !== 1'b0 || gr_s !== 4'b0000 || busy_s !== 1'b0) begin
          n_bad++; $display("FAIL rstmid_abandon: wv=%b grant=%b busy=%b, required 0/0000/0", wv_s, gr_s, busy_s);
        end
      end else begin
        if (t == 6) begin
          n_cmp++;
          if (rdy_s !== 4'b0001) begin
            n_bad++; $display("FAIL rstmid_winner: ready=%b, required 0001", rdy_s);
          end
        end
        n_cmp++;
        if (wv_s !== 1'b1) begin
          n_bad++; $display("FAIL rstmid_gap t=%0d: wv=%b, required 1", t, wv_s);
        end else begin
          ex = next_exp(); n_cmp++;
          if (!ex.ok || wa_s !== ex.addr || wd_s !== ex.data) begin
            n_bad++;
            $display("FAIL rstmid_write t=%0d: addr %0d data %0h, required addr %0d data %0h", t, wa_s, wd_s, ex.addr, ex.data);
          end
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL rstmid_drain: pending=%0d, required 0", exp_q.size());
    end
  endtask

  initial begin
    clk_in        = 1'b0;
    rst_n_in      = 1'b0;
    bus.req_valid = 4'b0000;
    bus.req_last  = 4'b0000;
    bus.req_addr  = 40'd0;
    bus.req_data  = 32'd0;
    test_reset();
    test_round_robin();
    test_burst_lock();
    test_bubble();
    test_max_burst();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
